clkroot_div: RTL and testbench

Parametrised, multi-channel clock root generator: each channel derives a divided clock from `clk` with a glitch-free enable and a divisor that can be changed on the fly. Each divided clock leaves a flop and passes through a per-channel clock root anchor buffer, so timing constraints can find the generated clock net by instance name. It sits in the clock/reset block, feeding slow peripheral clock roots such as the audio and SPI engines. Each channel also provides a `tick` strobe in the `clk` domain for logic that must stay synchronous to the source clock.

---
 rtl/clkroot_div.sv | 120 ++++++++++++
 tb/tb_clkroot_div.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clkroot_div.sv
// clkroot_div: multi-channel clock root generator.
//
// Each channel divides clk by an effective divisor D (div < 2 is treated as
// 2). It produces a near-50% duty clock that is high for D - floor(D/2)
// cycles and low for floor(D/2) cycles. The clock leaves a flop and passes
// through a per-channel anchor buffer, so constraints can find the generated
// clock net by instance name.
//
// A channel starts a period one cycle after en is seen while idle. When en
// drops, the channel always finishes the period in progress, so no runt phase
// is ever emitted. Only a reset can cut a period short.
//
// Ports:
//   clk      in   source clock
//   rst      in   synchronous active-high reset
//   en       in   [N_CH]        per-channel run request (level)
//   div      in   [N_CH*W_DIV]  per-channel divisor, channel c at div[c*W_DIV +: W_DIV]
//   clk_out  out  [N_CH]        divided clocks (flop -> anchor buffer)
//   tick     out  [N_CH]        clk-domain strobe coincident with clk_out rising
//   running  out  [N_CH]        channel is emitting periods (not idle)
module clkroot_div #(
  parameter int N_CH  = 1,
  parameter int W_DIV = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH*W_DIV-1:0]   div,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e           state_q;
    logic [W_DIV-1:0] cnt_q;      // index k of the next output cycle to emit
    logic [W_DIV-1:0] cur_div_q;  // divisor of the period in progress
    logic             clk_q;
    logic             tick_q;
    logic             run_q;

    logic [W_DIV-1:0] div_raw;
    logic [W_DIV-1:0] div_eff;
    logic [W_DIV-1:0] per_len;
    logic [W_DIV-1:0] hi_len;
    logic             last;

    always_comb begin
      div_raw = div[c*W_DIV +: W_DIV];
      div_eff = (div_raw < W_DIV'(2)) ? W_DIV'(2) : div_raw;
      // At k = 0 the new divisor is being captured this very edge, so the
      // period shape must already come from it, not from cur_div_q.
      per_len = (cnt_q == '0) ? div_eff : cur_div_q;
      hi_len  = per_len - (per_len >> 1);
      last    = (cnt_q == per_len - 1'b1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        cur_div_q <= W_DIV'(2);
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
        run_q     <= 1'b0;
      end else begin
        // running is delayed one cycle so that it rises and falls together
        // with the first and last registered output cycle of the channel.
        run_q <= (state_q != S_IDLE);
        case (state_q)
          S_IDLE: begin
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
            if (en[c]) state_q <= S_RUN;
          end
          S_RUN, S_DRAIN: begin
            if (cnt_q == '0) cur_div_q <= div_eff;
            clk_q  <= (cnt_q < hi_len);
            tick_q <= (cnt_q == '0);
            if (last) begin
              // Period boundary: the only place a channel may stop.
              cnt_q   <= '0;
              state_q <= en[c] ? S_RUN : S_IDLE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= en[c] ? S_RUN : S_DRAIN;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
          end
        endcase
      end
    end

    assign tick[c]    = tick_q;
    assign running[c] = run_q;

`ifdef GF180MCU
    (* keep *)
    gf180mcu_fd_sc_mcu9t5v0__clkbuf_16 magic_clkroot_anchor_u (
      .I (clk_q),
      .Z (clk_out[c])
    );
`else
    assign clk_out[c] = clk_q;
`endif
  end

endmodule

// File: tb/tb_clkroot_div.sv
// Testbench for clkroot_div (two channels, 8-bit divisors).
// A period-level reference model queues the expected output cycles of every
// period it schedules. A monitor pops one expected cycle per clock and
// compares it against the DUT. It also measures every clk_out phase against
// floor(D/2) of the period that phase began in.
module tb_clkroot_div;
  localparam int NC = 2;
  localparam int W  = 8;

  logic            clk;
  logic            rst;
  logic [NC-1:0]   en;
  logic [NC*W-1:0] div;
  logic [NC-1:0]   clk_out;
  logic [NC-1:0]   tick;
  logic [NC-1:0]   running;

  clkroot_div #(.N_CH(NC), .W_DIV(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div     (div),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // One expected output cycle for both channels.
  typedef struct packed {
    logic [NC-1:0]   c;
    logic [NC-1:0]   t;
    logic [NC-1:0]   r;
    logic [NC-1:0]   rc;   // reset at this edge
    logic [NC*8-1:0] mn;   // floor(D/2) of the period this cycle belongs to
  } exp_t;

  exp_t sb[$];

  // Per-channel entries: {mn[7:0], run, tick, clk}
  logic [10:0] pq [NC][$];
  bit          pend [NC];

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Reference model: each period is D cycles, high for D - D/2, tick at k=0.
  // A new period is scheduled whenever nothing is queued and en is high.
  exp_t        m_e;
  logic [10:0] m_ent;
  int          m_d;
  always @(posedge clk) begin
    m_e = '0;
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        pq[c].delete();
        pend[c] = 1'b0;
        m_e.rc[c] = 1'b1;
      end else begin
        if (pend[c]) begin
          m_d = eff_div(int'(div[c*W +: W]));
          for (int k = 0; k < m_d; k++)
            pq[c].push_back({8'(m_d / 2), 1'b1, (k == 0), (k < m_d - m_d / 2)});
          pend[c] = 1'b0;
        end
        m_ent = (pq[c].size() > 0) ? pq[c].pop_front() : 11'd0;
        m_e.c[c] = m_ent[0];
        m_e.t[c] = m_ent[1];
        m_e.r[c] = m_ent[2];
        m_e.mn[c*8 +: 8] = m_ent[10:3];
        if (pq[c].size() == 0 && en[c]) pend[c] = 1'b1;
      end
    end
    sb.push_back(m_e);
  end

  // Monitor: compare outputs and measure phase lengths.
  exp_t mo_e;
  int   ph_len [NC];
  int   ph_min [NC];
  bit   ph_lvl [NC];
  bit   ph_skip [NC];
  int   cyc_no = 0;
  always @(posedge clk) begin
    #1;
    cyc_no++;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty cycle=%0d", cyc_no);
    end else begin
      mo_e = sb.pop_front();
      for (int c = 0; c < NC; c++) begin
        total++;
        if ({clk_out[c], tick[c], running[c]} !== {mo_e.c[c], mo_e.t[c], mo_e.r[c]}) begin
          bad++;
          $display("FAIL ch%0d_outputs cycle=%0d got clk/tick/run=%b%b%b want=%b%b%b",
                   c, cyc_no, clk_out[c], tick[c], running[c], mo_e.c[c], mo_e.t[c], mo_e.r[c]);
        end
        if (mo_e.rc[c]) begin
          ph_skip[c] = 1'b1;
          ph_lvl[c]  = 1'b0;
          ph_len[c]  = 1;
        end else if (clk_out[c] === ph_lvl[c]) begin
          ph_len[c]++;
        end else begin
          if (!ph_skip[c]) begin
            total++;
            if (ph_len[c] < ph_min[c]) begin
              bad++;
              $display("FAIL ch%0d_runt_phase cycle=%0d got len=%0d want>=%0d",
                       c, cyc_no, ph_len[c], ph_min[c]);
            end
          end
          ph_lvl[c]  = clk_out[c];
          ph_len[c]  = 1;
          ph_min[c]  = int'(mo_e.mn[c*8 +: 8]);
          ph_skip[c] = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int c);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tick[c]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ch%0d_tick_timeout got=none want=tick within 600 cycles", c);
    end
  endtask

  int dl [4] = '{0, 1, 2, 255};

  initial begin
    rst = 1'b1;
    en  = '0;
    div = '0;
    for (int c = 0; c < NC; c++) begin
      ph_skip[c] = 1'b1; ph_len[c] = 0; ph_min[c] = 0; ph_lvl[c] = 1'b0;
    end
    cyc(3);
    rst = 1'b0;

    // Basic divide: ch0 /4, ch1 /5, enabled at cycle 10.
    div = {8'd5, 8'd4};
    cyc(7);
    en = 2'b11;
    cyc(40);
    en = 2'b00;
    cyc(12);

    // Divisor change mid-period: 6 -> 3 at k=2.
    div[0 +: W] = 8'd6;
    en[0] = 1'b1;
    wait_tick(0);
    cyc(1);
    div[0 +: W] = 8'd3;
    cyc(20);
    en[0] = 1'b0;
    cyc(12);

    // Disable at k=1, D=8.
    div[0 +: W] = 8'd8;
    en[0] = 1'b1;
    wait_tick(0);
    en[0] = 1'b0;
    cyc(15);

    // Disable then re-enable at k=5.
    en[0] = 1'b1;
    wait_tick(0);
    en[0] = 1'b0;
    cyc(4);
    en[0] = 1'b1;
    cyc(20);
    en[0] = 1'b0;
    cyc(12);

    // Small and edge divisors.
    foreach (dl[i]) begin
      div = {8'(dl[i]), 8'(dl[i])};
      en = 2'b11;
      cyc(dl[i] == 255 ? 520 : 12);
      en = 2'b00;
      cyc(dl[i] == 255 ? 260 : 6);
    end

    // Reset mid-period at k=3 of D=10, en held high.
    div[0 +: W] = 8'd10;
    en[0] = 1'b1;
    wait_tick(0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    div[0 +: W] = 8'd7;
    cyc(25);
    en[0] = 1'b0;
    cyc(12);

    // Random en/div toggling with rare resets.
    for (int i = 0; i < 10000; i++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(39) == 0) en[c] = ~en[c];
        if ($urandom_range(24) == 0)
          div[c*W +: W] = ($urandom_range(9) == 0) ? 8'($urandom_range(255))
                                                   : 8'($urandom_range(20));
      end
      rst = ($urandom_range(1999) == 0);
      cyc(1);
    end
    rst = 1'b0;
    en  = '0;
    cyc(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
